// File: rtl/sysid_pkg.sv
// sysid_pkg: shared constants for the system-ID register block.
//   - word offsets of every register in the map
//   - hardware revision reported in the capability word
//   - bit position of the clear command in the CTRL register
package sysid_pkg;

  localparam int OFF_ID             = 0;
  localparam int OFF_TIMESTAMP      = 1;
  localparam int OFF_CAPS           = 2;
  localparam int OFF_UPTIME_LO      = 3;
  localparam int OFF_UPTIME_HI_SNAP = 4;
  localparam int OFF_SECONDS        = 5;
  localparam int OFF_SCRATCH        = 6;
  localparam int OFF_CTRL           = 7;

  localparam logic [15:0] REVISION = 16'h0002;

  localparam int CTRL_CLR_BIT = 0;

  // Capability word: revision in the upper half, clock rate in MHz below.
  function automatic logic [31:0] caps_word(input int clk_hz);
    caps_word = {REVISION, 16'(clk_hz / 1_000_000)};
  endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// sysid_regs_if: Avalon-MM slave bus for the system-ID register block.
//   master modport: drives chipselect/address/read/write/writedata/byteenable,
//                   receives readdata/readdatavalid
//   slave modport : the reverse
interface sysid_regs_if #(
  parameter int ADDR_W = 3
);

  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output chipselect, address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  chipselect, address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_tick_gen.sv
// sysid_tick_gen: one-second prescaler.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   clr     : restart the prescaler from 0 on the next edge
//   tick    : high during the cycle the prescaler sits at CLK_HZ-1
module sysid_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int              PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_reg;

  assign tick = (presc_reg == TC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_reg <= '0;
    end else if (clr || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: multi-register system-ID slave with latency-1 reads.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : Avalon-MM slave (chipselect, address, read, write, writedata,
//             byteenable in; readdata, readdatavalid out)
// Holds ID, build timestamp, capabilities, a 64-bit uptime counter with an
// atomic high-half snapshot, a seconds counter and a byte-writable scratch.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID    = 32'h70AB_CDF0,
  parameter logic [31:0] TIMESTAMP = 32'h4F3B_2A04,
  parameter int          CLK_HZ    = 50_000_000,
  parameter int          ADDR_W    = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  sysid_regs_if.slave  bus
);

  localparam logic [31:0] CAPS = caps_word(CLK_HZ);

  logic [63:0] uptime_reg;
  logic [31:0] snap_reg;
  logic [31:0] seconds_reg;
  logic [31:0] scratch_reg;
  logic [31:0] scratch_next;
  logic [31:0] readdata_reg;
  logic        readdatavalid_reg;
  logic [31:0] rdata_next;

  logic rd_en;
  logic wr_en;
  logic scratch_wr;
  logic clr;
  logic tick;

  assign rd_en      = bus.chipselect && bus.read;
  assign wr_en      = bus.chipselect && bus.write;
  assign scratch_wr = wr_en && (bus.address == ADDR_W'(OFF_SCRATCH));
  assign clr        = wr_en && (bus.address == ADDR_W'(OFF_CTRL))
                      && bus.writedata[CTRL_CLR_BIT];

  sysid_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (tick)
  );

  // Per-lane scratch merge: untouched lanes keep their old byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign scratch_next[gi*8 +: 8] = (scratch_wr && bus.byteenable[gi])
                                     ? bus.writedata[gi*8 +: 8]
                                     : scratch_reg[gi*8 +: 8];
  end

  // Read mux works on current register contents, so a read returns the
  // value from before this edge's updates. CTRL and unmapped offsets read 0.
  always_comb begin
    rdata_next = '0;
    if (bus.address == ADDR_W'(OFF_ID))                  rdata_next = SYS_ID;
    else if (bus.address == ADDR_W'(OFF_TIMESTAMP))      rdata_next = TIMESTAMP;
    else if (bus.address == ADDR_W'(OFF_CAPS))           rdata_next = CAPS;
    else if (bus.address == ADDR_W'(OFF_UPTIME_LO))      rdata_next = uptime_reg[31:0];
    else if (bus.address == ADDR_W'(OFF_UPTIME_HI_SNAP)) rdata_next = snap_reg;
    else if (bus.address == ADDR_W'(OFF_SECONDS))        rdata_next = seconds_reg;
    else if (bus.address == ADDR_W'(OFF_SCRATCH))        rdata_next = scratch_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uptime_reg        <= '0;
      snap_reg          <= '0;
      seconds_reg       <= '0;
      scratch_reg       <= '0;
      readdata_reg      <= '0;
      readdatavalid_reg <= 1'b0;
    end else begin
      readdatavalid_reg <= rd_en;
      if (rd_en) begin
        readdata_reg <= rdata_next;
      end

      // Snapshot the high half of the same sample whose low half is returned.
      if (rd_en && (bus.address == ADDR_W'(OFF_UPTIME_LO))) begin
        snap_reg <= uptime_reg[63:32];
      end

      // Clear has priority over the free-running increment and the tick.
      if (clr) begin
        uptime_reg  <= '0;
        seconds_reg <= '0;
      end else begin
        uptime_reg <= uptime_reg + 64'd1;
        if (tick) begin
          seconds_reg <= seconds_reg + 32'd1;
        end
      end

      scratch_reg <= scratch_next;
    end
  end

  assign bus.readdata      = readdata_reg;
  assign bus.readdatavalid = readdatavalid_reg;

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised successor to the single-word system-ID slave: a multi-register Avalon-MM slave with registered (latency-1) reads.
- Holds the system ID, build timestamp, capability word, a 64-bit free-running uptime counter with atomic high-half snapshot, a seconds counter and a byte-writable scratch register.
- Sits on the CPU data master bus; software uses it to confirm the hardware/software match and for coarse timekeeping.

Parameters:
- SYS_ID, 32'h70AB_CDF0, value returned at ID offset.
- TIMESTAMP, 32'h4F3B_2A04, build timestamp returned at TIMESTAMP offset.
- CLK_HZ, 50_000_000, clk frequency; seconds prescaler terminal count is CLK_HZ-1 (must be >= 2).
- ADDR_W, 3, word-address width; 8 word slots.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on clk.
- chipselect  in  1  slave select.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, qualified by chipselect.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for one cycle, 1 cycle after an accepted read.

Behaviour:
- Register map (word offsets):
  - 0 ID: RO, SYS_ID.
  - 1 TIMESTAMP: RO.
  - 2 CAPS: RO, {16'h0002 revision, CLK_HZ/1_000_000 in [15:0]}.
  - 3 UPTIME_LO: RO, uptime[31:0]; a read also copies uptime[63:32] into the snap register, same edge.
  - 4 UPTIME_HI_SNAP: RO, snap register.
  - 5 SECONDS: RO.
  - 6 SCRATCH: RW.
  - 7 CTRL: WO; reads return 0.
- Unmapped offsets (ADDR_W > 3) read 0; writes to them are ignored.
- Writes to RO offsets are ignored.
- Reset (reset_n low at a clk edge):
  - readdata=0, readdatavalid=0, uptime=0, snap=0, prescaler=0, SECONDS=0, SCRATCH=0.
  - Reset mid-read suppresses the pending readdatavalid.
- Read:
  - chipselect&read at edge N -> readdata and readdatavalid=1 at edge N+1.
  - readdatavalid is 0 otherwise; readdata holds its last value when not valid.
  - Back-to-back reads allowed every cycle; no waitrequest.
  - Read value is the register contents before edge N's updates, e.g. UPTIME_LO returns the pre-increment value.
- Uptime:
  - 64-bit counter, +1 every clk; wraps from all-ones to 0.
  - Snap captures the high half of the same 64-bit sample whose low half is returned.
- Seconds:
  - Prescaler counts 0..CLK_HZ-1. At the terminal count it returns to 0 and SECONDS increments.
  - SECONDS wraps from 2^32-1 to 0.
- SCRATCH write: each byte lane updates only where byteenable[i]=1.
- CTRL write, bit0=1 (clear):
  - Next edge: uptime=0, prescaler=0, SECONDS=0; snap and SCRATCH unaffected.
  - Clear beats a simultaneous increment or terminal count.
  - Other CTRL bits are ignored.
- Read and write in the same cycle: both are performed; the read returns the old value.

Decomposition:
- Package sysid_pkg:
  - word-offset constants (OFF_ID..OFF_CTRL);
  - REVISION = 16'h0002;
  - CTRL_CLR_BIT = 0.
- Sub-module sysid_tick_gen:
  - parameter CLK_HZ; inputs clk, reset_n, clr; output tick (one-cycle pulse at terminal count);
  - drives the SECONDS increment.

Test Plan:
- Reset, then read offsets 0,1,2 -> 32'h70AB_CDF0, 32'h4F3B_2A04, 32'h0002_0032; each readdatavalid exactly 1 cycle after its read.
- Force uptime to 64'h0000_0001_FFFF_FFFF (backdoor), read UPTIME_LO at that edge, then UPTIME_HI_SNAP -> 32'hFFFF_FFFF then 32'h0000_0001, even though the live counter has rolled to 0x2_xxxx.
- CLK_HZ=10: run 25 cycles after reset -> SECONDS=2. Write CTRL=1 on the terminal-count cycle -> SECONDS=0, UPTIME_LO small.
- Write SCRATCH=32'hDEAD_BEEF with be=4'hF, then 32'h1234_5678 with be=4'b0101 -> read returns 32'hDE34_BE78.
- Assert reset_n low on the cycle after a read -> readdatavalid stays 0; SCRATCH reads 0 afterwards.
- Write to offset 0, then read offset 0 -> still SYS_ID; read offset 7 -> 0.
